// File: rtl/sa_mult_pkg.sv
// Shared types, defaults and the round-robin grant helper for the
// shift-and-add multiplier arbiter.
package sa_mult_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 4;

    // rr_pick works on a fixed-width vector so any NREQ up to MAX_NREQ can use it
    localparam int MAX_NREQ  = 32;
    localparam int MAX_IDW   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [MAX_NREQ-1:0] rr_pick(
        input logic [MAX_NREQ-1:0] valid,
        input logic [31:0]         ptr,
        input logic [31:0]         n
    );
        logic [MAX_NREQ-1:0] grant;
        logic                found;
        logic [MAX_IDW-1:0]  idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (32'(i) < n) begin
                idx = MAX_IDW'((ptr + 32'(i)) % n);
                if (!found && valid[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/sa_mult_core.sv
// Iterative shift-and-add multiply engine: one multiplier bit per clock,
// done pulses on the final step with the finished product on p.
module sa_mult_core
    import sa_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] a1;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   b1;
    logic [CW-1:0]      cnt;
    logic               busy;

    // p is the accumulator including the current step, so it is final on the done cycle
    assign acc_next = b1[0] ? (acc + a1) : acc;
    assign done     = busy && (cnt == LAST);
    assign p        = acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1   <= '0;
            b1   <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (load) begin
            a1   <= {{WIDTH{1'b0}}, a};
            b1   <= b;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            acc  <= acc_next;
            a1   <= a1 << 1;
            b1   <= b1 >> 1;
            cnt  <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sa_mult_arbiter.sv
// Round-robin arbiter sharing one shift-and-add multiplier among NREQ
// requesters, with a single ID-tagged response channel.
module sa_mult_arbiter
    import sa_mult_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NREQ  = DEF_NREQ,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_p
);

    state_t             state;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     id_q;
    logic [IDW-1:0]     gnt_id;
    logic [IDW-1:0]     ptr_next;
    logic [NREQ-1:0]    grant;
    logic               accept;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic               core_done;
    logic [2*WIDTH-1:0] core_p;

    assign grant  = NREQ'(rr_pick(MAX_NREQ'(req_valid), 32'(rr_ptr), 32'(NREQ)));
    assign accept = (state == IDLE) && (|grant);

    // reset is folded in so no grant is offered while the block is held in reset
    assign req_ready = ((state == IDLE) && rst_n) ? grant : '0;

    always_comb begin
        gnt_id = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gnt_id = IDW'(i);
                a_sel  = req_a[i*WIDTH +: WIDTH];
                b_sel  = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_next = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

    sa_mult_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .a     (a_sel),
        .b     (b_sel),
        .done  (core_done),
        .p     (core_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_p     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        id_q   <= gnt_id;
                        rr_ptr <= ptr_next;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (core_done) begin
                        rsp_p     <= core_p;
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // retiring takes a full cycle; the next grant is offered from IDLE
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sa_mult_arbiter.sv
// Randomized scoreboard bench for sa_mult_arbiter against a cycle-count
// reference model of arbitration, latency and handshakes.
module tb_sa_mult_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_p;

    typedef struct {
        int unsigned id;
        int unsigned p;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // model: 0 = waiting for a grant, 1 = multiplying, 2 = response pending
    int   m_phase = 0;
    int   m_left  = 0;
    int   m_ptr   = 0;

    sa_mult_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: sampled mid-cycle, predicts grants and response timing
    always @(negedge clk) begin
        int unsigned exp_grant;
        int          g;
        int unsigned av;
        int unsigned bv;
        if (!rst_n) begin
            checkOutput("reset_req_ready", 32'(req_ready), 0);
            checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
            checkOutput("reset_rsp_id", 32'(rsp_id), 0);
            checkOutput("reset_rsp_p", 32'(rsp_p), 0);
            sb_q.delete();
            m_phase = 0;
            m_left  = 0;
            m_ptr   = 0;
        end else begin
            exp_grant = 0;
            g = -1;
            if (m_phase == 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % NREQ]) begin
                        g = (m_ptr + k) % NREQ;
                    end
                end
                if (g >= 0) exp_grant = 32'(1) << g;
            end
            checkOutput("req_ready", 32'(req_ready), exp_grant);
            checkOutput("rsp_valid", 32'(rsp_valid), (m_phase == 2) ? 1 : 0);
            case (m_phase)
                0: begin
                    if (g >= 0) begin
                        av = 32'(req_a[g*WIDTH +: WIDTH]);
                        bv = 32'(req_b[g*WIDTH +: WIDTH]);
                        sb_q.push_back('{id: g, p: (av * bv) % 65536});
                        m_ptr   = (g + 1) % NREQ;
                        m_phase = 1;
                        m_left  = WIDTH;
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: begin
                    if (rsp_ready) m_phase = 0;
                end
            endcase
        end
    end

    // Monitor: compares every presented response against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb_q.size() == 0) begin
                checkOutput("rsp_unexpected", 1, 0);
            end else begin
                checkOutput("rsp_id", 32'(rsp_id), sb_q[0].id);
                checkOutput("rsp_p", 32'(rsp_p), sb_q[0].p);
                if (rsp_ready) void'(sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setOperands(input int idx, input int unsigned a, input int unsigned b);
        req_a[idx*WIDTH +: WIDTH] = WIDTH'(a);
        req_b[idx*WIDTH +: WIDTH] = WIDTH'(b);
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic ready);
        req_valid = valid;
        rsp_ready = ready;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        applyStimulus('0, 1'b1);
        while ((m_phase != 0 || sb_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain_done", (m_phase == 0 && sb_q.size() == 0) ? 1 : 0, 1);
        tick();
    endtask

    // One isolated operation with an explicit latency measurement
    task automatic singleOp(input int idx, input int unsigned a, input int unsigned b, input string name);
        int n;
        setOperands(idx, a, b);
        applyStimulus(NREQ'(1) << idx, 1'b1);
        tick();
        req_valid = '0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput(name, n - 1, WIDTH);
        tick();
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        req_a = '0;
        req_b = '0;
        applyStimulus('0, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        singleOp(0, 13, 11, "latency_13x11");
        singleOp(2, 255, 255, "latency_255x255");
        singleOp(1, 0, 200, "latency_zero");

        // all requesters continuously valid: rotation starts from the current pointer
        for (int i = 0; i < NREQ; i++) setOperands(i, 17 + 29 * i, 3 + 41 * i);
        applyStimulus('1, 1'b1);
        repeat (5 * (WIDTH + 2) + 3) tick();
        drain(40);

        // back-pressure: response held while another requester waits
        setOperands(1, 200, 99);
        setOperands(3, 7, 250);
        applyStimulus(4'b0010, 1'b0);
        tick();
        req_valid = 4'b1000;
        n = 0;
        while (!rsp_valid && n < 30) begin
            tick();
            n++;
        end
        checkOutput("hold_reached", 32'(rsp_valid), 1);
        repeat (5) tick();
        checkOutput("hold_valid", 32'(rsp_valid), 1);
        rsp_ready = 1'b1;
        tick();
        tick();
        req_valid = '0;
        drain(40);

        // reset in the middle of a multiply drops it and restarts the pointer
        singleOp(2, 9, 9, "latency_pre_reset");
        setOperands(3, 123, 45);
        applyStimulus(4'b1000, 1'b1);
        tick();
        req_valid = '0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(rsp_valid), 0);
        checkOutput("async_rst_ready", 32'(req_ready), 0);
        checkOutput("async_rst_p", 32'(rsp_p), 0);
        req_valid = '1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (WIDTH + 4) tick();
        drain(40);

        // random traffic with operands changing every cycle
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                case ($urandom_range(0, 5))
                    0: setOperands(i, 0, $urandom_range(0, 255));
                    1: setOperands(i, 255, 255);
                    default: setOperands(i, $urandom_range(0, 255), $urandom_range(0, 255));
                endcase
            end
            applyStimulus(($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom_range(0, 15)),
                          ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
            tick();
        end
        drain(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
